load_store_unit: RTL and testbench

- Memory-initiator side of the data-memory interface. Sits between the datapath/control and the byte-addressed, big-endian, 64-bit-wide data memory.
- Memory side: combinational read, synchronous full-doubleword write, no byte enables.
- Turns sized RISC-V loads (LB/LH/LW/LD/LBU/LHU/LWU) into read-and-extract operations.
- Turns sized stores (SB/SH/SW/SD) into either a direct write or a read-modify-write (RMW).
- Uses a valid/ready request and response handshake toward the core.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_extend.sv | 24 ++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM encoding and size decode for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Access size in bytes; the unsigned variants share the low two bits with the signed ones.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory bundles with modports
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] endereco;
  logic [63:0] write_data;
  logic [63:0] read_data;

  modport master (
    output mem_read, mem_write, endereco, write_data,
    input  read_data
  );

  modport slave (
    input  mem_read, mem_write, endereco, write_data,
    output read_data
  );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - picks the big-endian leading field of a doubleword and sign/zero extends it
module load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] read_data,
  input  logic [2:0]  funct3,
  output logic [63:0] ext_data
);

  always_comb begin
    ext_data = '0;
    case (funct3)
      F3_B:    ext_data = {{56{read_data[63]}}, read_data[63:56]};
      F3_H:    ext_data = {{48{read_data[63]}}, read_data[63:48]};
      F3_W:    ext_data = {{32{read_data[63]}}, read_data[63:32]};
      F3_D:    ext_data = read_data;
      F3_BU:   ext_data = {56'd0, read_data[63:56]};
      F3_HU:   ext_data = {48'd0, read_data[63:48]};
      F3_WU:   ext_data = {32'd0, read_data[63:32]};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sized load/store sequencer toward a 64-bit big-endian data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 2048
) (
  input logic       clk,
  input logic       rst_n,
  lsu_req_if.slave  core,
  lsu_mem_if.master mem
);

  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [63:0] wr_data_q;
  logic [2:0]  f3_q;
  logic        write_q;
  logic        err_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic        accept;
  logic        req_err;
  logic [63:0] ext_data;
  logic [6:0]  shamt;
  logic [63:0] field_mask;
  logic [63:0] merged;

  assign accept = core.req_valid && (state_q == ST_IDLE);

  // Any in-range address keeps addr+7 inside memory, so the 64-bit sum never wraps.
  assign req_err = (core.req_funct3 == 3'b111)
                || (core.req_write && core.req_funct3[2])
                || (core.req_addr > 64'(MEM_BYTES - 8));

  // The stored field occupies the most significant 8N bits of the doubleword.
  assign shamt      = 7'd64 - {size_bytes(f3_q), 3'b000};
  assign field_mask = {64{1'b1}} << shamt;
  assign merged     = (mem.read_data & ~field_mask) | ((wdata_q << shamt) & field_mask);

  load_extend u_load_extend (
    .read_data (mem.read_data),
    .funct3    (f3_q),
    .ext_data  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                        state_d = ST_RESP;
          else if (!core.req_write)           state_d = ST_LOAD;
          else if (core.req_funct3 == F3_D)   state_d = ST_WRITE;
          else                                state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wr_data_q   <= '0;
      f3_q        <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= (state_d == ST_LOAD) || (state_d == ST_RMW_RD);
      mem_write_q <= (state_d == ST_WRITE);

      if (accept) begin
        addr_q  <= core.req_addr;
        wdata_q <= core.req_wdata;
        f3_q    <= core.req_funct3;
        write_q <= core.req_write;
        err_q   <= req_err;
        rdata_q <= '0;
      end

      if (state_q == ST_LOAD && !write_q) begin
        rdata_q <= ext_data;
      end

      // SD goes straight from IDLE, so its data comes from the request itself.
      if (state_d == ST_WRITE) begin
        wr_data_q <= (state_q == ST_RMW_RD) ? merged : core.req_wdata;
      end
    end
  end

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q && (state_q == ST_RESP);

  assign mem.mem_read   = mem_read_q;
  assign mem.mem_write  = mem_write_q;
  assign mem.endereco   = addr_q;
  assign mem.write_data = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench for load_store_unit with a big-endian byte memory model
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if rq ();
  lsu_mem_if mb ();

  load_store_unit #(.MEM_BYTES(2048)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (rq),
    .mem   (mb)
  );

  logic [7:0]  mem [0:2047];
  logic [63:0] mrd;

  always_comb begin
    mrd = '0;
    if (mb.endereco <= 64'd2040)
      for (int i = 0; i < 8; i++) mrd[63-8*i -: 8] = mem[int'(mb.endereco) + i];
  end
  assign mb.read_data = mrd;

  always @(posedge clk) begin
    if (mb.mem_write && mb.endereco <= 64'd2040)
      for (int i = 0; i < 8; i++) mem[int'(mb.endereco) + i] = mb.write_data[63-8*i -: 8];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  int          lat, nrd, nwr;
  logic [63:0] rdat, wdat;
  logic        er;

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output int o_lat, output logic [63:0] o_rd,
                       output logic o_err, output int o_nrd, output int o_nwr,
                       output logic [63:0] o_wdat);
    int waited;
    o_lat = -1; o_rd = '0; o_err = 1'b0; o_nrd = 0; o_nwr = 0; o_wdat = '0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_write = wr; rq.req_funct3 = f3;
    rq.req_addr = addr; rq.req_wdata = wd;
    waited = 0;
    while (!rq.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    rq.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mb.mem_read) o_nrd++;
      if (mb.mem_write) begin
        o_nwr++;
        o_wdat = mb.write_data;
      end
      if (rq.resp_valid) begin
        o_lat = c; o_rd = rq.resp_rdata; o_err = rq.resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [2:0]  ld_f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
  logic [63:0] ld_exp [7] = '{64'hFFFFFFFFFFFFFF80, 64'h80, 64'hFFFFFFFFFFFF80C0, 64'h80C0,
                              64'hFFFFFFFF80C0A090, 64'h80C0A090, 64'h80C0A09088848281};

  logic        e_wr   [3] = '{1'b0, 1'b0, 1'b1};
  logic [2:0]  e_f3   [3] = '{3'b011, 3'b111, 3'b100};
  logic [63:0] e_addr [3] = '{64'd2041, 64'd40, 64'd40};

  logic        b_wr [3] = '{1'b0, 1'b1, 1'b0};
  logic [2:0]  b_f3 [3] = '{3'b011, 3'b010, 3'b100};
  logic [63:0] b_a  [3] = '{64'd8, 64'd16, 64'd16};
  logic [63:0] b_wd [3] = '{64'd0, 64'hCAFEF00D, 64'd0};
  logic [63:0] b_ex [3] = '{64'hAB00000000000006, 64'd0, 64'hCA};
  int          acc_c [3];
  int          resp_c [3];
  logic [63:0] b_rd [3];

  initial begin
    logic [7:0] m40 [8] = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};
    logic       saw_wr;
    int         acc, done, brd, bwr;

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mem[40+i]   = m40[i];
      mem[16+i]   = 8'(i + 1);
      mem[24+i]   = 8'hFF;
      mem[32+i]   = 8'(8'h11 * (i + 1));
      mem[2040+i] = 8'(i + 1);
    end
    mem[15] = 8'h06;

    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_funct3 = '0;
    rq.req_addr = '0; rq.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(rq.req_ready), 64'd1);
    check("rst_outs", {rq.resp_valid, rq.resp_err, mb.mem_read, mb.mem_write}, 64'd0);
    check("rst_endereco", mb.endereco, 64'd0);
    check("rst_wdata", mb.write_data, 64'd0);
    check("rst_rdata", rq.resp_rdata, 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      issue(1'b0, ld_f3[k], 64'd40, 64'd0, lat, rdat, er, nrd, nwr, wdat);
      check($sformatf("load40_f3_%0d", ld_f3[k]), rdat, ld_exp[k]);
      check($sformatf("load40_lat_%0d", ld_f3[k]), 64'(lat), 64'd2);
    end

    issue(1'b0, 3'b011, 64'd2040, 64'd0, lat, rdat, er, nrd, nwr, wdat);
    check("ld_last_addr", rdat, 64'h0102030405060708);
    check("ld_last_err", 64'(er), 64'd0);

    issue(1'b1, 3'b000, 64'd8, 64'h12345678000000AB, lat, rdat, er, nrd, nwr, wdat);
    check("sb_rd_wr_cycles", {32'(nrd), 32'(nwr)}, {32'd1, 32'd1});
    check("sb_write_data", wdat, 64'hAB00000000000006);
    check("sb_lat", 64'(lat), 64'd3);
    check("sb_rdata", rdat, 64'd0);
    issue(1'b0, 3'b011, 64'd8, 64'd0, lat, rdat, er, nrd, nwr, wdat);
    check("sb_readback", rdat, 64'hAB00000000000006);

    issue(1'b1, 3'b011, 64'd24, 64'h0E, lat, rdat, er, nrd, nwr, wdat);
    check("sd_rd_wr_cycles", {32'(nrd), 32'(nwr)}, {32'd0, 32'd1});
    check("sd_write_data", wdat, 64'h000000000000000E);
    check("sd_lat", 64'(lat), 64'd2);
    issue(1'b0, 3'b011, 64'd24, 64'd0, lat, rdat, er, nrd, nwr, wdat);
    check("sd_readback", rdat, 64'hE);

    for (int k = 0; k < 3; k++) begin
      issue(e_wr[k], e_f3[k], e_addr[k], 64'hFFFF, lat, rdat, er, nrd, nwr, wdat);
      check($sformatf("err%0d_flag", k), 64'(er), 64'd1);
      check($sformatf("err%0d_rdata", k), rdat, 64'd0);
      check($sformatf("err%0d_mem_cycles", k), 64'(nrd + nwr), 64'd0);
      check($sformatf("err%0d_lat", k), 64'(lat), 64'd1);
    end

    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_write = 1'b1; rq.req_funct3 = 3'b010;
    rq.req_addr = 64'd32; rq.req_wdata = 64'h99;
    @(negedge clk);
    rq.req_valid = 1'b0;
    saw_wr = 1'b0;
    for (int c = 0; c < 10 && !saw_wr; c++) begin
      if (mb.mem_write) saw_wr = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_saw_write", 64'(saw_wr), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_drop", 64'(mb.mem_write), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_bytes", {mem[32], mem[33], mem[34], mem[35]}, 64'h11223344);
    rst_n = 1'b1;
    check("rst_mid_ready", 64'(rq.req_ready), 64'd1);
    issue(1'b0, 3'b011, 64'd32, 64'd0, lat, rdat, er, nrd, nwr, wdat);
    check("rst_mid_ld", rdat, 64'h1122334455667788);
    check("rst_mid_ld_lat", 64'(lat), 64'd2);

    acc = 0; done = 0; brd = 0; bwr = 0;
    for (int c = 0; c < 40 && done < 3; c++) begin
      @(negedge clk);
      if (mb.mem_read) brd++;
      if (mb.mem_write) bwr++;
      if (rq.resp_valid) begin
        resp_c[done] = c; b_rd[done] = rq.resp_rdata; done++;
      end
      if (rq.req_ready && acc < 3) begin
        rq.req_valid = 1'b1; rq.req_write = b_wr[acc]; rq.req_funct3 = b_f3[acc];
        rq.req_addr = b_a[acc]; rq.req_wdata = b_wd[acc];
        acc_c[acc] = c; acc++;
      end else if (acc == 3) begin
        rq.req_valid = 1'b0;
      end
    end
    rq.req_valid = 1'b0;
    check("b2b_done", 64'(done), 64'd3);
    if (done == 3) begin
      check("b2b_ld_lat", 64'(resp_c[0] - acc_c[0]), 64'd2);
      check("b2b_sw_accept", 64'(acc_c[1]), 64'(resp_c[0] + 1));
      check("b2b_sw_lat", 64'(resp_c[1] - acc_c[1]), 64'd3);
      check("b2b_lbu_accept", 64'(acc_c[2]), 64'(resp_c[1] + 1));
      for (int k = 0; k < 3; k++) check($sformatf("b2b_rdata%0d", k), b_rd[k], b_ex[k]);
    end
    check("b2b_mem_cycles", {32'(brd), 32'(bwr)}, {32'd3, 32'd1});
    issue(1'b0, 3'b011, 64'd16, 64'd0, lat, rdat, er, nrd, nwr, wdat);
    check("b2b_sw_readback", rdat, 64'hCAFEF00D05060708);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
